// File: rtl/nrzi_stuff_encoder.sv
// -----------------------------------------------------------------------------
// nrzi_stuff_encoder
//
// HS transmit back end: bit stuffing followed by NRZI encoding, with a
// valid/ready handshake towards the serializer. One unencoded bit is accepted
// per clock. After MAX_RUN consecutive accepted 1s, a 0 is inserted while
// din_ready is held low for one cycle. The resulting bit stream is NRZI-encoded
// (0 = toggle, 1 = hold) onto a registered line output.
//
// Optional feature (macro NRZI_STUFF_EOP_EN):
//   Adds the eop_req input and an EOP state. This state generates the HS EOP
//   pattern (raw 0 followed by seven 1s, never stuffed) and then returns the
//   line to IDLE_LEVEL.
//
// Parameters:
//   MAX_RUN    - number of consecutive accepted 1s that triggers a stuffed 0
//   IDLE_LEVEL - line level after reset, after flush and after an EOP
//   RUN_W      - width of the run counter (derived from MAX_RUN; leave alone)
//
// Ports:
//   clk        in   serial clock
//   rst        in   synchronous, active-high reset
//   din        in   unencoded data bit
//   din_valid  in   din is valid this cycle
//   din_ready  out  din is accepted this cycle (combinational)
//   stuff_en   in   enables bit stuffing (low = raw NRZI, for SYNC/EOP)
//   flush      in   end the packet and return the line to IDLE_LEVEL
//   eop_req    in   (NRZI_STUFF_EOP_EN only) start an HS EOP
//   dout       out  NRZI line level (registered)
//   dout_valid out  dout carries a data, stuff or EOP bit (registered)
// -----------------------------------------------------------------------------
module nrzi_stuff_encoder #(
    parameter int   MAX_RUN    = 6,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   RUN_W      = $clog2(MAX_RUN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    input  logic stuff_en,
    input  logic flush,
`ifdef NRZI_STUFF_EOP_EN
    input  logic eop_req,
`endif
    output logic dout,
    output logic dout_valid
);

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_ZERO = '0;
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STUFF = 2'd2
`ifdef NRZI_STUFF_EOP_EN
        , ST_EOP = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q,   run_d;
    logic             dout_q,  dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic             accept;
    logic             line_ref;
    logic [RUN_W-1:0] run_inc;

`ifdef NRZI_STUFF_EOP_EN
    // EOP bit index (0..7).
    logic [2:0] eop_cnt_q, eop_cnt_d;
    // Set for the single cycle after an EOP. In that cycle the line is
    // treated as already being at IDLE_LEVEL.
    logic       eop_done_q, eop_done_d;
`endif

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // Ready is gated by flush and rst. This means that a bit offered during a
    // flush or a reset is never accepted, so it is never silently discarded.
`ifdef NRZI_STUFF_EOP_EN
    assign din_ready = (state_q != ST_STUFF) && (state_q != ST_EOP) && !flush && !rst;
`else
    assign din_ready = (state_q != ST_STUFF) && !flush && !rst;
`endif

    assign accept = din_valid && din_ready;

    // Level that the NRZI encoding of the current bit is relative to.
`ifdef NRZI_STUFF_EOP_EN
    assign line_ref = eop_done_q ? IDLE_LEVEL : dout_q;
`else
    assign line_ref = dout_q;
`endif

    // Saturating increment. With stuffing disabled, long runs of 1s (for
    // example SYNC/EOP pass-through) must not wrap the counter back into a
    // range that could trigger a spurious stuff later on.
    assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
`ifdef NRZI_STUFF_EOP_EN
        eop_cnt_d    = eop_cnt_q;
        eop_done_d   = 1'b0;
`endif

        case (state_q)
            ST_STUFF: begin
                // The stuffed 0 is emitted whatever stuff_en is now. The
                // decision to stuff was taken at the triggering accept.
                dout_d       = ~dout_q;
                dout_valid_d = 1'b1;
                run_d        = RUN_ZERO;
                state_d      = ST_DATA;
            end

`ifdef NRZI_STUFF_EOP_EN
            ST_EOP: begin
                // Raw EOP pattern is 0 then seven 1s: toggle once, then hold.
                dout_d       = (eop_cnt_q == 3'd0) ? ~dout_q : dout_q;
                dout_valid_d = 1'b1;
                run_d        = RUN_ZERO;
                if (eop_cnt_q == 3'd7) begin
                    eop_cnt_d  = 3'd0;
                    eop_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    eop_cnt_d = eop_cnt_q + 3'd1;
                end
            end
`endif

            default: begin
                // IDLE and DATA behave the same; a bubble holds the line and
                // keeps run/state so a run of 1s spans bubbles.
                dout_d = line_ref;
                if (accept) begin
                    dout_valid_d = 1'b1;
                    state_d      = ST_DATA;
                    if (!din) begin
                        dout_d = ~line_ref;
                        run_d  = RUN_ZERO;
                    end else begin
                        dout_d = line_ref;
                        run_d  = run_inc;
                        if (stuff_en && (run_inc == RUN_MAX)) begin
                            state_d = ST_STUFF;
                        end
                    end
                end
`ifdef NRZI_STUFF_EOP_EN
                // A bit accepted in the same cycle has already been encoded
                // above and goes out first. The EOP is never stuffed, so it
                // takes precedence over a stuff that the same bit would
                // otherwise trigger.
                if (eop_req) begin
                    state_d   = ST_EOP;
                    eop_cnt_d = 3'd0;
                    run_d     = RUN_ZERO;
                end
`endif
            end
        endcase

        // flush overrides everything, including a pending stuff or EOP.
        if (flush) begin
            state_d      = ST_IDLE;
            run_d        = RUN_ZERO;
            dout_d       = IDLE_LEVEL;
            dout_valid_d = 1'b0;
`ifdef NRZI_STUFF_EOP_EN
            eop_cnt_d    = 3'd0;
            eop_done_d   = 1'b0;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so all registers
    // sample their next values at the same edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            run_q        <= RUN_ZERO;
            dout_q       <= IDLE_LEVEL;
            dout_valid_q <= 1'b0;
`ifdef NRZI_STUFF_EOP_EN
            eop_cnt_q    <= 3'd0;
            eop_done_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef NRZI_STUFF_EOP_EN
            eop_cnt_q    <= eop_cnt_d;
            eop_done_q   <= eop_done_d;
`endif
        end
    end

    // Line outputs come straight from flops; din has no combinational path
    // to dout.
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// -----------------------------------------------------------------------------
// tb_nrzi_stuff_encoder
//
// Directed bench for nrzi_stuff_encoder (MAX_RUN=6, IDLE_LEVEL=1). Inputs are
// driven 1 time unit after a rising edge. din_ready is sampled before the next
// edge. dout/dout_valid are sampled 1 time unit after that edge. Define
// NRZI_STUFF_EOP_EN to also exercise the EOP generator.
// -----------------------------------------------------------------------------
module tb_nrzi_stuff_encoder;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic din_valid;
    logic din_ready;
    logic stuff_en;
    logic flush;
    logic dout;
    logic dout_valid;
`ifdef NRZI_STUFF_EOP_EN
    logic eop_req = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nrzi_stuff_encoder #(
        .MAX_RUN    (6),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .stuff_en   (stuff_en),
        .flush      (flush),
`ifdef NRZI_STUFF_EOP_EN
        .eop_req    (eop_req),
`endif
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    // Apply one cycle of stimulus. Return the din_ready seen before the edge.
    // On return, the registered outputs of that cycle are stable.
    task automatic drive(input logic d, input logic v, input logic s,
                         input logic f, output logic rdy);
        din       = d;
        din_valid = v;
        stuff_en  = s;
        flush     = f;
        #1;
        rdy = din_ready;
        @(posedge clk);
        #1;
    endtask

    // Return to IDLE between scenarios (no checks).
    task automatic idle_flush();
        logic rdy;
        drive(1'b0, 1'b0, 1'b1, 1'b1, rdy);
        drive(1'b0, 1'b0, 1'b1, 1'b0, rdy);
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; stuff_en = 1'b1; flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_in_rst: got %b expected 0", din_ready);
        end
        vectors++;
        if ({dout, dout_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_line: got %b expected 10", {dout, dout_valid});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_after: got %b expected 1", din_ready);
        end
    endtask

    task automatic test_encode();
        logic bits [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic lines[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic rdy;
        for (int i = 0; i < 4; i++) begin
            drive(bits[i], 1'b1, 1'b1, 1'b0, rdy);
            vectors++;
            if (rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL enc_ready[%0d]: got %b expected 1", i, rdy);
            end
            vectors++;
            if ({dout, dout_valid} !== {lines[i], 1'b1}) begin
                miscompares++;
                $display("FAIL enc_line[%0d]: got %b expected %b", i,
                         {dout, dout_valid}, {lines[i], 1'b1});
            end
        end
        // A flush ends the packet: the line returns to idle and is not valid.
        drive(1'b1, 1'b1, 1'b1, 1'b1, rdy);
        vectors++;
        if (rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: got %b expected 0", rdy);
        end
        vectors++;
        if ({dout, dout_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_line: got %b expected 10", {dout, dout_valid});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, rdy);
    endtask

    task automatic test_stuffing();
        logic rdy;
        drive(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({dout, dout_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL stuff_lead: got %b expected 01", {dout, dout_valid});
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
            vectors++;
            if ({rdy, dout, dout_valid} !== 3'b101) begin
                miscompares++;
                $display("FAIL stuff_one[%0d]: rdy/line got %b expected 101", i,
                         {rdy, dout, dout_valid});
            end
        end
        // Stuff cycle: seventh 1 offered but refused; line toggles.
        drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b011) begin
            miscompares++;
            $display("FAIL stuff_bit: rdy/line got %b expected 011", {rdy, dout, dout_valid});
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b111) begin
            miscompares++;
            $display("FAIL stuff_seventh: rdy/line got %b expected 111", {rdy, dout, dout_valid});
        end
        idle_flush();
    endtask

    task automatic test_no_stuff();
        logic rdy;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, rdy);
            vectors++;
            if ({rdy, dout, dout_valid} !== 3'b111) begin
                miscompares++;
                $display("FAIL nostuff_one[%0d]: rdy/line got %b expected 111", i,
                         {rdy, dout, dout_valid});
            end
        end
        // The run is saturated at 6, so one more 1 with stuffing enabled
        // reaches MAX_RUN again and stuffs. A wrapped counter would not stuff.
        drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b111) begin
            miscompares++;
            $display("FAIL nostuff_enable: rdy/line got %b expected 111", {rdy, dout, dout_valid});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b001) begin
            miscompares++;
            $display("FAIL nostuff_saturated: rdy/line got %b expected 001", {rdy, dout, dout_valid});
        end
        idle_flush();
    endtask

    task automatic test_bubble_flush();
        logic rdy;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
            vectors++;
            if ({rdy, dout, dout_valid} !== 3'b111) begin
                miscompares++;
                $display("FAIL bub_one[%0d]: rdy/line got %b expected 111", i,
                         {rdy, dout, dout_valid});
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, rdy);
            vectors++;
            if ({rdy, dout, dout_valid} !== 3'b110) begin
                miscompares++;
                $display("FAIL bub_gap[%0d]: rdy/line got %b expected 110", i,
                         {rdy, dout, dout_valid});
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b111) begin
            miscompares++;
            $display("FAIL bub_sixth: rdy/line got %b expected 111", {rdy, dout, dout_valid});
        end
        // STUFF cycle with flush: stuff bit dropped, line idles.
        drive(1'b1, 1'b1, 1'b1, 1'b1, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL bub_flush_stuff: rdy/line got %b expected 010", {rdy, dout, dout_valid});
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b101) begin
            miscompares++;
            $display("FAIL bub_resume: rdy/line got %b expected 101", {rdy, dout, dout_valid});
        end
        idle_flush();
    endtask

    task automatic test_back_to_back();
        logic rdy;
        // Five 1s then a 0 clears the run; stuffing needs six fresh 1s.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        drive(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b101) begin
            miscompares++;
            $display("FAIL b2b_zero: rdy/line got %b expected 101", {rdy, dout, dout_valid});
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
            vectors++;
            if ({rdy, dout, dout_valid} !== 3'b101) begin
                miscompares++;
                $display("FAIL b2b_one[%0d]: rdy/line got %b expected 101", i,
                         {rdy, dout, dout_valid});
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b011) begin
            miscompares++;
            $display("FAIL b2b_stuff: rdy/line got %b expected 011", {rdy, dout, dout_valid});
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b101) begin
            miscompares++;
            $display("FAIL b2b_after: rdy/line got %b expected 101", {rdy, dout, dout_valid});
        end
        idle_flush();
    endtask

    task automatic test_reset_mid_packet();
        logic rdy;
        drive(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        vectors++;
        if ({dout, dout_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL rstmid_data: got %b expected 01", {dout, dout_valid});
        end
        // rst together with flush: rst wins, result is the reset state.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, rdy);
        rst = 1'b0;
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL rstmid_reset: rdy/line got %b expected 010", {rdy, dout, dout_valid});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL rstmid_idle: rdy/line got %b expected 110", {rdy, dout, dout_valid});
        end
    endtask

`ifdef NRZI_STUFF_EOP_EN
    task automatic test_eop();
        logic rdy;
        eop_req = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, rdy);
        eop_req = 1'b0;
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL eop_req: rdy/line got %b expected 110", {rdy, dout, dout_valid});
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, rdy);
            vectors++;
            if ({rdy, dout, dout_valid} !== 3'b001) begin
                miscompares++;
                $display("FAIL eop_bit[%0d]: rdy/line got %b expected 001", i,
                         {rdy, dout, dout_valid});
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, rdy);
        vectors++;
        if ({rdy, dout, dout_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL eop_idle: rdy/line got %b expected 110", {rdy, dout, dout_valid});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_encode();
        test_stuffing();
        test_no_stuff();
        test_bubble_flush();
        test_back_to_back();
        test_reset_mid_packet();
`ifdef NRZI_STUFF_EOP_EN
        test_eop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nrzi_stuff_encoder.md
Name: nrzi_stuff_encoder

Overview:
- Serial-domain HS transmit back end that combines bit stuffing and NRZI encoding in one block, with a valid/ready handshake.
- Accepts one unencoded bit per clock from the serializer.
- Inserts a stuffed 0 after a parametrised run of consecutive 1s, then NRZI-encodes onto a registered line output.
- Sits between the TX serializer and the analog line driver. Stalls upstream via din_ready while a stuff bit is emitted.

Parameters:
- MAX_RUN, 6: number of consecutive accepted 1s that triggers a stuffed 0.
- IDLE_LEVEL, 1'b1: line level driven after reset and after flush.
- RUN_W, $clog2(MAX_RUN+1): width of the run counter (derived; not to be overridden).

Ports:
- clk  input  1  serial clock (480 MHz for HS).
- rst  input  1  synchronous, active-high reset.
- din  input  1  unencoded data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block accepts din this cycle.
- stuff_en  input  1  enables bit stuffing. Low = raw NRZI only (SYNC/EOP pass-through).
- flush  input  1  single-cycle request to end the packet and return the line to IDLE_LEVEL.
- dout  output  1  NRZI line level (registered).
- dout_valid  output  1  dout carries a data or stuff bit this cycle (registered).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: dout=IDLE_LEVEL, dout_valid=0, run counter=0, state=IDLE, din_ready=1 from the first cycle after reset.
- States: IDLE, DATA, STUFF (plus EOP under the optional macro).
- din_ready is combinational: (state != STUFF) && !flush && !rst.
- Accept condition: din_valid && din_ready. Latency is one cycle from accept to dout/dout_valid.
- Accepted 0: dout toggles; run cleared to 0; dout_valid=1; state=DATA.
- Accepted 1: dout holds; run incremented; dout_valid=1; state=DATA.
- Stuff trigger: if the accepted 1 brings run to MAX_RUN and stuff_en=1 on that same cycle, next state is STUFF.
- STUFF state: din_ready=0 for exactly one cycle. dout toggles (stuffed 0), dout_valid=1, run cleared to 0, then state returns to DATA.
- stuff_en is sampled only at the triggering accept. Once STUFF is entered the stuff bit is always emitted.
- stuff_en=0: run counter saturates at MAX_RUN and never wraps; no stuffing occurs.
- Bubble (din_valid=0, not STUFF): dout holds, dout_valid=0. Run counter and state are preserved, so a run spans bubbles.
- flush: takes effect on the next edge.
  - dout=IDLE_LEVEL, dout_valid=0, run=0, state=IDLE.
  - Overrides a pending STUFF; the stuff bit is dropped.
  - din_ready is low in the flush cycle, so no bit is lost silently.
- flush and rst together: rst wins (identical result).
- Reset mid-packet: outputs return to reset values on the next edge, regardless of state.
- No combinational path from din to dout.

Optional Feature:
- Macro: NRZI_STUFF_EOP_EN.
- Defined:
  - Adds input eop_req (1 bit) and state EOP.
  - eop_req is accepted when state is IDLE or DATA and flush=0.
  - Accepted eop_req emits the HS EOP: raw bits 0 then seven 1s, 8 cycles, NRZI-encoded, dout_valid=1, stuffing forced off.
  - din_ready=0 for all 8 cycles.
  - Afterwards: state=IDLE, dout forced to IDLE_LEVEL, run=0.
  - eop_req together with an accepted din: the din bit is emitted first, then the EOP starts next cycle.
  - flush during EOP aborts it (flush behaviour).
- Undefined: no eop_req port and no EOP state; EOP must be supplied as raw bits with stuff_en=0.

Test Plan:
- Reset: rst=1 for 4 cycles, then release -> dout=1, dout_valid=0, din_ready=1.
- Encoding: din 0,1,0,1 (valid) -> dout 0,0,1,1 one cycle after each accept; dout_valid=1 throughout.
- Stuffing: stuff_en=1, din=1 x7 after a leading 0 -> six holds at 0, then din_ready=0 for one cycle with dout toggling to 1, then seventh 1 accepted and held at 1.
- stuff_en=0: eight 1s -> dout constant, din_ready never drops, run saturates at 6.
- Bubble and flush:
  - Five 1s, two valid=0 cycles, one more 1 -> STUFF still triggers after the sixth 1.
  - flush asserted in the STUFF cycle -> next cycle dout=1, dout_valid=0, no stuff bit emitted.
- EOP (NRZI_STUFF_EOP_EN): from line=1, eop_req -> dout 0,0,0,0,0,0,0,0 over 8 cycles (one toggle, seven holds), din_ready=0, then dout=1, dout_valid=0.
